// File: rtl/toyrisc_arith_pkg.sv
// Shared definitions for the ToyRISC arithmetic unit and its initiators:
// unit function codes, multi-word op encodings, sequencer FSM states and
// the per-word drive decode.
package toyrisc_arith_pkg;

    localparam int WORD_W = 32;

    // Function codes understood by the arithmetic unit's func input.
    localparam logic [2:0] FUNC_INC  = 3'b000;
    localparam logic [2:0] FUNC_DEC  = 3'b001;
    localparam logic [2:0] FUNC_ADD  = 3'b010;
    localparam logic [2:0] FUNC_SUB  = 3'b011;
    localparam logic [2:0] FUNC_INCC = 3'b100;
    localparam logic [2:0] FUNC_ADC  = 3'b110;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_INC = 2'b10,
        OP_DEC = 2'b11
    } arithOpT;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seqStateT;

    // One word's worth of drive onto the unit's leftIn/rightIn/func.
    typedef struct packed {
        logic [WORD_W-1:0] left;
        logic [WORD_W-1:0] right;
        logic [2:0]        func;
    } arithDriveT;

    // Quiescent drive: the unit sees a harmless 0 + 0 add outside RUN.
    localparam arithDriveT IDLE_DRIVE = '{left: '0, right: '0, func: FUNC_ADD};

    // Word 0 uses a carry-free function so the unit's carry register state
    // left over from idle cycles never matters; higher words chain the carry.
    // SUB and DEC reuse add-with-carry: a borrow chain is an add of the
    // complemented right operand, where carry=1 means "no borrow".
    function automatic arithDriveT driveWord(input arithOpT op,
                                             input logic [WORD_W-1:0] a,
                                             input logic [WORD_W-1:0] b,
                                             input logic first);
        arithDriveT d;
        d.left  = a;
        d.right = '0;
        d.func  = FUNC_ADD;
        case (op)
            OP_ADD: begin
                d.func  = first ? FUNC_ADD : FUNC_ADC;
                d.right = b;
            end
            OP_SUB: begin
                d.func  = first ? FUNC_SUB : FUNC_ADC;
                d.right = first ? b : ~b;
            end
            OP_INC: begin
                d.func  = first ? FUNC_INC : FUNC_INCC;
            end
            OP_DEC: begin
                d.func  = first ? FUNC_DEC : FUNC_ADC;
                d.right = first ? '0 : {WORD_W{1'b1}};
            end
            default: d = IDLE_DRIVE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mw_arith_seq.sv
// Multi-word arithmetic sequencer: accepts a WORDS x 32-bit ADD/SUB/INC/DEC
// request and walks the external 32-bit arithmetic unit one word per cycle,
// least-significant word first, collecting result words into rsp_sum.
module mw_arith_seq
    import toyrisc_arith_pkg::*;
#(
    parameter int WORDS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [WORDS*32-1:0]   req_a,
    input  logic [WORDS*32-1:0]   req_b,
    output logic [31:0]           arith_left,
    output logic [31:0]           arith_right,
    output logic [2:0]            arith_func,
    input  logic [31:0]           arith_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORDS*32-1:0]   rsp_sum
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seqStateT                   state;
    seqStateT                   stateNext;
    arithOpT                    opReg;
    // Operand words still to be presented; word 0 is driven straight from
    // the request at acceptance, so only words 1..WORDS-1 are held here.
    logic [WORDS-2:0][31:0]     aRest;
    logic [WORDS-2:0][31:0]     bRest;
    logic [IDX_W-1:0]           wordIdx;
    logic [WORDS-1:0][31:0]     sumReg;
    arithDriveT                 driveReg;
    arithDriveT                 driveNext;
    logic                       accept;
    logic                       reqReadyReg;
    logic                       rspValidReg;

    assign req_ready   = reqReadyReg;
    assign rsp_valid   = rspValidReg;
    assign rsp_sum     = sumReg;
    assign arith_left  = driveReg.left;
    assign arith_right = driveReg.right;
    assign arith_func  = driveReg.func;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next state and the drive for the word presented in the coming cycle.
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        stateNext = state;
        driveNext = IDLE_DRIVE;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                    driveNext = driveWord(arithOpT'(req_op), req_a[31:0],
                                          req_b[31:0], 1'b1);
                end
            end
            RUN: begin
                // Back-to-back issue: the unit reloads its carry every edge,
                // so the next word must follow with no gap.
                if (wordIdx == LAST_IDX) stateNext = DONE;
                else driveNext = driveWord(opReg, aRest[0], bRest[0], 1'b0);
            end
            DONE: begin
                if (rsp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Datapath: operand latch and shift, result collection, registered outputs.
    // NOTE: operand and result registers are reset too so a reset in RUN or
    // DONE leaves rsp_sum at zero rather than stale data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opReg       <= OP_ADD;
            aRest       <= '0;
            bRest       <= '0;
            wordIdx     <= '0;
            sumReg      <= '0;
            driveReg    <= IDLE_DRIVE;
            reqReadyReg <= 1'b1;
            rspValidReg <= 1'b0;
        end else begin
            driveReg    <= driveNext;
            reqReadyReg <= (stateNext == IDLE);
            rspValidReg <= (stateNext == DONE);
            if (accept) begin
                opReg   <= arithOpT'(req_op);
                aRest   <= req_a[WORDS*32-1:32];
                bRest   <= req_b[WORDS*32-1:32];
                wordIdx <= '0;
            end else if (state == RUN) begin
                // Results enter at the top and shift down; after WORDS
                // captures word 0 sits at the bottom.
                sumReg  <= {arith_result, sumReg[WORDS-1:1]};
                aRest   <= aRest >> 32;
                bRest   <= bRest >> 32;
                wordIdx <= wordIdx + 1'b1;
            end
        end
    end

endmodule
